// File: rtl/kronos_types.sv
// Shared Kronos type/helper package. Pipe structs live here; buffers carry
// them as plain WIDTH-bit vectors.
package kronos_types;

    // Bits needed to hold the values 0..n, e.g. an occupancy count of n entries.
    function automatic int clog2p1(input int n);
        int r;
        r = 0;
        while ((1 << r) < (n + 1)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/kronos_pipe_buffer.sv
// Elastic in-order pipestage holding up to DEPTH packets, with flush and an
// optional registered pipe_in_rdy that cuts the out_rdy -> in_rdy timing path.
module kronos_pipe_buffer
    import kronos_types::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 2,
    parameter int REG_RDY = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            pipe_in_data,
    input  logic                        pipe_in_vld,
    output logic                        pipe_in_rdy,
    output logic [WIDTH-1:0]            pipe_out_data,
    output logic                        pipe_out_vld,
    input  logic                        pipe_out_rdy,
    output logic [clog2p1(DEPTH)-1:0]   count
);

    localparam int CW = clog2p1(DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop, wr_en;

    // Explicit wrap keeps non-power-of-2 depths correct.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        push     = pipe_in_vld & pipe_in_rdy;
        pop      = pipe_out_vld & pipe_out_rdy;
        wr_en    = push & ~flush & ~rst;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; the head is only meaningful while pipe_out_vld is high.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= pipe_in_data;
    end

    assign pipe_out_vld  = (count_q != '0);
    assign pipe_out_data = mem_q[rd_ptr_q];
    assign count         = count_q;

    generate
        if (REG_RDY != 0) begin : g_reg_rdy
            logic rdy_q, rdy_d;
            always_comb rdy_d = (count_d < CW'(DEPTH));
            always_ff @(posedge clk) begin
                if (rst) rdy_q <= 1'b1;
                else     rdy_q <= rdy_d;
            end
            assign pipe_in_rdy = rdy_q;
        end else begin : g_comb_rdy
            // When full, a pop this cycle frees the slot the push writes after the edge.
            assign pipe_in_rdy = (count_q < CW'(DEPTH)) | pipe_out_rdy;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= CW'(DEPTH));
            assert (!(push && (count_q == CW'(DEPTH)) && ((REG_RDY != 0) || !pop)));
        end
    end

endmodule
